// File: rtl/hex_display_sequencer.sv
// Stepping 8-bit counter shown on two 7-segment digits via one time-shared decoder.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN suppresses a zero high digit.
module hex_display_sequencer #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       up,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   output logic       load_ready,
   input  logic       blink_en,
   output logic [7:0] count,
   output logic       tick,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [6:0]    SEG_OFF   = 7'h7F;
   localparam logic [6:0]    SEG_ZERO  = 7'h40;
`ifdef HEX_LEADING_ZERO_BLANK_EN
   localparam logic [6:0]    HEX1_RST  = SEG_OFF;
`else
   localparam logic [6:0]    HEX1_RST  = SEG_ZERO;
`endif

   typedef enum logic {
      SCAN_LO = 1'b0,
      SCAN_HI = 1'b1
   } scan_t;

   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;
   logic          blank;
   scan_t         scan_sel;
   logic [3:0]    nib;
   logic [6:0]    seg;

   // Active-low g..a segment patterns
   function automatic logic [6:0] decode_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Counter, prescaler and load handshake; a load overrides a coincident step
   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         count      <= 8'h00;
         tick       <= 1'b0;
         load_ready <= 1'b0;
      end else begin
         load_ready <= 1'b1;
         tick       <= 1'b0;
         if (load_valid && load_ready) begin
            count <= load_data;
            presc <= '0;
         end else if (!run) begin
            presc <= '0;
         end else if (presc == PRE_MAX) begin
            presc <= '0;
            count <= up ? count + 8'd1 : count - 8'd1;
            tick  <= 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Free-running blink phase, independent of run
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign blank = blink_en && !blink_on;

   always_comb begin
      nib = count[3:0];
      if (scan_sel == SCAN_HI) nib = count[7:4];
   end

   assign seg = decode_seg(nib);

   // Scan scheduler: the single decoder serves HEX0 then HEX1 on alternate cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_sel <= SCAN_LO;
         HEX0     <= SEG_ZERO;
         HEX1     <= HEX1_RST;
      end else begin
         case (scan_sel)
            SCAN_LO: begin
               HEX0     <= blank ? SEG_OFF : seg;
               scan_sel <= SCAN_HI;
            end
            default: begin
`ifdef HEX_LEADING_ZERO_BLANK_EN
               HEX1     <= (blank || count[7:4] == 4'h0) ? SEG_OFF : seg;
`else
               HEX1     <= blank ? SEG_OFF : seg;
`endif
               scan_sel <= SCAN_LO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer with TICK_DIV=4, BLINK_DIV=8.
module tb_hex_display_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       up;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       blink_en;
   logic [7:0] count;
   logic       tick;
   logic [6:0] HEX0;
   logic [6:0] HEX1;

   int errors = 0;
   int checks = 0;

`ifdef HEX_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] HEX1_Z = 7'h7F;
`else
   localparam logic [6:0] HEX1_Z = 7'h40;
`endif

   hex_display_sequencer #(.TICK_DIV(4), .BLINK_DIV(8)) dut (
      .clk(clk), .rst(rst), .run(run), .up(up),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .blink_en(blink_en), .count(count), .tick(tick), .HEX0(HEX0), .HEX1(HEX1)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; up = 1'b1; load_valid = 1'b0; load_data = 8'h00; blink_en = 1'b0;
      cyc(); cyc(); cyc();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", load_ready); end
      checks++; if (HEX0 !== 7'h40) begin errors++; $display("FAIL reset_hex0 got=%h exp=40", HEX0); end
      checks++; if (HEX1 !== HEX1_Z) begin errors++; $display("FAIL reset_hex1 got=%h exp=%h", HEX1, HEX1_Z); end
      rst = 1'b0;
      cyc();
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", load_ready); end
   endtask

   task automatic test_count_up();
      run = 1'b1; up = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         checks++;
         if (tick !== (i % 4 == 0)) begin errors++; $display("FAIL up_tick cyc=%0d got=%b exp=%b", i, tick, (i % 4 == 0)); end
         checks++;
         if (count !== 8'(i / 4)) begin errors++; $display("FAIL up_count cyc=%0d got=%h exp=%h", i, count, 8'(i / 4)); end
      end
      cyc(); cyc();
      checks++; if (HEX0 !== 7'h12) begin errors++; $display("FAIL up_hex0 got=%h exp=12", HEX0); end
      checks++; if (HEX1 !== HEX1_Z) begin errors++; $display("FAIL up_hex1 got=%h exp=%h", HEX1, HEX1_Z); end
   endtask

   task automatic test_wrap();
      load_valid = 1'b1; load_data = 8'hFF;
      cyc();
      load_valid = 1'b0;
      checks++; if (count !== 8'hFF) begin errors++; $display("FAIL wrap_load got=%h exp=FF", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL wrap_load_tick got=%b exp=0", tick); end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++;
         if (tick !== (i == 4)) begin errors++; $display("FAIL wrap_tick cyc=%0d got=%b exp=%b", i, tick, (i == 4)); end
      end
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL wrap_up got=%h exp=00", count); end
      up = 1'b0;
      for (int i = 1; i <= 4; i++) cyc();
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL wrap_down_tick got=%b exp=1", tick); end
      checks++; if (count !== 8'hFF) begin errors++; $display("FAIL wrap_down got=%h exp=FF", count); end
      cyc(); cyc();
      checks++; if (HEX0 !== 7'h0E) begin errors++; $display("FAIL wrap_hex0 got=%h exp=0E", HEX0); end
      checks++; if (HEX1 !== 7'h0E) begin errors++; $display("FAIL wrap_hex1 got=%h exp=0E", HEX1); end
   endtask

   task automatic test_load_collision();
      up = 1'b1; run = 1'b1;
      load_valid = 1'b1; load_data = 8'h10;
      cyc();
      load_valid = 1'b0;
      cyc(); cyc(); cyc();
      checks++; if (count !== 8'h10) begin errors++; $display("FAIL coll_pre got=%h exp=10", count); end
      load_valid = 1'b1; load_data = 8'hA7;
      cyc();
      load_valid = 1'b0;
      checks++; if (count !== 8'hA7) begin errors++; $display("FAIL coll_count got=%h exp=A7", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL coll_tick got=%b exp=0", tick); end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++;
         if (tick !== (i == 4)) begin errors++; $display("FAIL coll_next_tick cyc=%0d got=%b exp=%b", i, tick, (i == 4)); end
      end
      checks++; if (count !== 8'hA8) begin errors++; $display("FAIL coll_next got=%h exp=A8", count); end
   endtask

   task automatic test_run_hold();
      run = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         checks++;
         if (count !== 8'hA8 || tick !== 1'b0) begin
            errors++; $display("FAIL hold cyc=%0d got=%h/%b exp=A8/0", i, count, tick);
         end
      end
      run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++;
         if (tick !== (i == 4)) begin errors++; $display("FAIL resume_tick cyc=%0d got=%b exp=%b", i, tick, (i == 4)); end
      end
      checks++; if (count !== 8'hA9) begin errors++; $display("FAIL resume_count got=%h exp=A9", count); end
   endtask

   task automatic test_blink();
      logic       off;
      logic [6:0] e0;
      logic [6:0] e1;
      rst = 1'b1; run = 1'b0; blink_en = 1'b0; load_valid = 1'b0;
      cyc(); cyc();
      rst = 1'b0; load_valid = 1'b1; load_data = 8'h12; blink_en = 1'b1;
      for (int n = 1; n <= 32; n++) begin
         cyc();
         if (n == 2) load_valid = 1'b0;
         if (n >= 4 && (n % 8) >= 2) begin
            off = ((n / 8) % 2) == 1;
            e0  = off ? 7'h7F : 7'h24;
            e1  = off ? 7'h7F : 7'h79;
            checks++;
            if (HEX0 !== e0) begin errors++; $display("FAIL blink_hex0 n=%0d got=%h exp=%h", n, HEX0, e0); end
            checks++;
            if (HEX1 !== e1) begin errors++; $display("FAIL blink_hex1 n=%0d got=%h exp=%h", n, HEX1, e1); end
         end
      end
      blink_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      run = 1'b1; up = 1'b1;
      load_valid = 1'b1; load_data = 8'h3C;
      cyc();
      load_valid = 1'b0;
      cyc(); cyc();
      checks++; if (count !== 8'h3C) begin errors++; $display("FAIL mid_count got=%h exp=3C", count); end
      checks++; if (HEX0 !== 7'h46) begin errors++; $display("FAIL mid_hex0 got=%h exp=46", HEX0); end
      checks++; if (HEX1 !== 7'h30) begin errors++; $display("FAIL mid_hex1 got=%h exp=30", HEX1); end
      rst = 1'b1;
      cyc();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL mid_rst_count got=%h exp=00", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got=%b exp=0", tick); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", load_ready); end
      checks++; if (HEX0 !== 7'h40) begin errors++; $display("FAIL mid_rst_hex0 got=%h exp=40", HEX0); end
      checks++; if (HEX1 !== HEX1_Z) begin errors++; $display("FAIL mid_rst_hex1 got=%h exp=%h", HEX1, HEX1_Z); end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_load_collision();
      test_run_hold();
      test_blink();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Drives the two on-board 7-segment digits (HEX1:HEX0) from an internal 8-bit value that steps at a programmable rate, replacing the fixed debug value.
- Owns a single shared hex-to-segment decoder and time-shares it between the two digits with a 2-phase scan scheduler.
- Adds run/direction control, a valid/ready load port and display blinking.
- Sits between board-level switches/keys and the HEX pins.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per count step (1 Hz at 50 MHz); legal range >= 2.
- BLINK_DIV, 25_000_000, clk cycles per blink phase (on or off); legal range >= 2.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- run  input  1  1 = prescaler counts and value steps; 0 = prescaler held at 0, value frozen.
- up  input  1  1 = increment on step, 0 = decrement.
- load_valid  input  1  load request.
- load_data  input  8  value to load.
- load_ready  output  1  load can be accepted this cycle.
- blink_en  input  1  1 = blank both digits during the blink off-phase.
- count  output  8  current value (registered).
- tick  output  1  one-cycle pulse on the edge where count steps.
- HEX0  output  7  low digit segments, active-low, bit order g..a.
- HEX1  output  7  high digit segments, same encoding.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=8'h00, tick=0, load_ready=0.
  - Prescaler=0, blink counter=0, blink phase=on, scan_sel=0.
  - HEX0=HEX1=7'b1000000 ('0').
  - All outputs hold these values while rst is high; reset mid-count or mid-load discards everything.
- load_ready=1 on every cycle after reset deasserts. A load is accepted when load_valid && load_ready:
  - count<=load_data and prescaler<=0; tick=0 that cycle.
  - Load has priority over a coincident step (the step is dropped).
- Prescaler counts 0..TICK_DIV-1 while run=1. On the edge where it equals TICK_DIV-1 (and no load):
  - prescaler<=0.
  - count<=count+1 if up=1, else count-1, modulo 256 (8'hFF+1 -> 8'h00, 8'h00-1 -> 8'hFF).
  - tick<=1 for exactly one cycle.
- run=0 forces prescaler<=0, so a count step is always a full TICK_DIV cycles after run rises. Toggling up never resets the prescaler.
- Blink counter runs continuously (independent of run) 0..BLINK_DIV-1. At wrap, the blink phase toggles.
- Blank condition: blink_en=1 and blink phase=off. With blink_en=0 the phase still advances but is ignored.
- Scan scheduler: 2-state FSM, SCAN_LO <-> SCAN_HI, alternating every clk cycle starting from SCAN_LO after reset. One decoder instance, with its input muxed by state:
  - SCAN_LO: HEX0 <= blank ? 7'h7F : decode(count[3:0]); HEX1 holds.
  - SCAN_HI: HEX1 <= blank ? 7'h7F : decode(count[7:4]); HEX0 holds.
- Latency: any change of count or blank is visible on both HEX outputs within 2 clk cycles after count updates. Digits may differ by one value for at most 1 cycle.
- Decode table, active-low, for 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex of 7-bit pattern).

Optional Feature:
- HEX_LEADING_ZERO_BLANK_EN.
- Defined: in SCAN_HI, if count[7:4]==4'h0 then HEX1<=7'h7F (leading zero suppressed). Reset value of HEX1 becomes 7'h7F. HEX0 is unaffected.
- Undefined: HEX1 always shows the decoded upper nibble; no extra logic is synthesized.

Test Plan (TICK_DIV=4, BLINK_DIV=8):
- Reset, then run=1, up=1 for 20 cycles -> tick pulses every 4 cycles; count 00->05; HEX0=7'h12 ('5') and HEX1=7'h40 within 2 cycles of the last tick.
- Load FF with run=1, up=1, wait one step -> count=00 (wrap), tick=1 once. Then up=0, one step -> count=FF, HEX0=HEX1=7'h0E.
- load_valid=1, load_data=8'hA7 in the same cycle the prescaler hits 3 -> count=A7 (no step, tick=0); next tick exactly 4 cycles later -> A8.
- run=0 for 10 cycles -> count frozen, tick=0. Then run=1 -> first tick exactly 4 cycles after run rises.
- blink_en=1, count=12 -> HEX0/HEX1 alternate every 8 cycles between 7'h24/7'h79 and 7'h7F/7'h7F, switching within 2 cycles of each phase edge.
- Assert rst mid-run with count=3C, HEX showing '3C' -> next cycle count=00, tick=0, load_ready=0, HEX0=HEX1=7'h40 (with HEX_LEADING_ZERO_BLANK_EN: HEX1=7'h7F).
